// File: rtl/down_counter_tc.sv
// Loadable down counter with one-cycle terminal-count pulse.
// Ports: clk, rst (async low), din, load, en, auto_reload -> count, tc, busy.
module down_counter_tc #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] rld_q, rld_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;

  logic run_en;
  logic at_one;
  logic at_zero;

  assign run_en  = (state_q == RUN) && en;
  assign at_one  = (count_q == ONE);
  assign at_zero = (count_q == ZERO);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rld_d   = rld_q;
    tc_d    = 1'b0;
    busy_d  = busy_q;
    unique case (1'b1)
      load: begin
        count_d = din;
        rld_d   = din;
        if (din != ZERO) begin
          state_d = RUN;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      (!load && run_en && at_one): begin
        count_d = ZERO;
        tc_d    = 1'b1;
        // One-shot parks in HOLD; busy drops on the same edge as tc.
        if (!auto_reload) begin
          state_d = HOLD;
          busy_d  = 1'b0;
        end
      end
      // Only reachable in RUN after an auto-reload arrival at 0.
      (!load && run_en && at_zero): begin
        count_d = rld_q;
      end
      (!load && run_en && !at_one && !at_zero): begin
        count_d = count_q - ONE;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= ZERO;
      rld_q   <= ZERO;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rld_q   <= rld_d;
      tc_q    <= tc_d;
      busy_q  <= busy_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign busy  = busy_q;

endmodule
